// File: rtl/lcd_controller.sv
// lcd_controller: HD44780 power-up, init sequence and timed write transactions
module lcd_controller #(
  parameter int CLK_MHZ  = 50,
  parameter int PWRUP_US = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_enable,
  input  logic [9:0] lcd_bus,
  output logic       lcd_busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);
  localparam int E_CYC     = CLK_MHZ;
  localparam int SHORT_CYC = 50 * CLK_MHZ;
  localparam int LONG_CYC  = 2000 * CLK_MHZ;
  localparam int PWRUP_CYC = PWRUP_US * CLK_MHZ;
  localparam int MAX_CYC   = PWRUP_CYC > LONG_CYC ? PWRUP_CYC : LONG_CYC;
  localparam int CW        = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] E_L     = CW'(E_CYC);
  localparam logic [CW-1:0] SHORT_L = CW'(SHORT_CYC);
  localparam logic [CW-1:0] LONG_L  = CW'(LONG_CYC);
  localparam logic [CW-1:0] PWR_L   = CW'(PWRUP_CYC);
  typedef enum logic [1:0] {POWER_UP, INIT, READY, SEND} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, len;
  logic [1:0] idx, idx_n;
  logic rs_q, rs_n, rw_q, rw_n, done;
  logic [7:0] dat, dat_n;
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
  endfunction
  // state, counter and the latched rs/data presented to the panel
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= POWER_UP;
      cnt   <= '0;
      idx   <= '0;
      rs_q  <= 1'b0;
      rw_q  <= 1'b0;
      dat   <= 8'h00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      rs_q  <= rs_n;
      rw_q  <= rw_n;
      dat   <= dat_n;
    end
  end
  // length of the current phase; a discarded read occupies a single cycle
  always_comb begin
    len  = state == POWER_UP ? PWR_L :
           state == INIT ? (idx == 2'd2 ? LONG_L : SHORT_L) :
           rw_q ? CW'(1) :
           (!rs_q && dat >= 8'h01 && dat <= 8'h03) ? LONG_L : SHORT_L;
    done = cnt == len - CW'(1);
  end
  // next-state sequencing: power-up wait, four init commands, then requests
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    rs_n    = rs_q;
    rw_n    = rw_q;
    dat_n   = dat;
    case (state)
      POWER_UP: if (done) begin
        state_n = INIT;
        cnt_n   = '0;
        idx_n   = 2'd0;
        rs_n    = 1'b0;
        rw_n    = 1'b0;
        dat_n   = init_cmd(2'd0);
      end
      INIT: if (done) begin
        cnt_n   = '0;
        state_n = idx == 2'd3 ? READY : INIT;
        idx_n   = idx + 2'd1;
        dat_n   = idx == 2'd3 ? dat : init_cmd(idx + 2'd1);
      end
      READY: begin
        cnt_n = '0;
        if (lcd_enable) begin
          state_n = SEND;
          rw_n    = lcd_bus[8];
          rs_n    = lcd_bus[8] ? rs_q : lcd_bus[9];
          dat_n   = lcd_bus[8] ? dat : lcd_bus[7:0];
        end
      end
      SEND: if (done) begin
        state_n = READY;
        cnt_n   = '0;
      end
      default: state_n = POWER_UP;
    endcase
  end
  assign lcd_busy = state != READY;
  assign lcd_e    = (state == INIT || (state == SEND && !rw_q)) && cnt != '0 && cnt <= E_L;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_data = dat;
endmodule
